// File: rtl/mdu_issue.sv
// mdu_issue: request-side sequencer for the shift-accumulate mul/div engine.
//
// Accepts RISC-V M-extension ops on a valid/ready request channel, starts the
// engine with a one-cycle pulse, holds the engine operand/mode pins stable for
// the whole calculation, picks the architectural result half and returns it on
// a valid/ready response channel. Divide-by-zero and signed divide overflow
// are answered locally without starting the engine.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i/req_ready_o      request handshake
//   req_op_i, req_a_i, req_b_i   op code (0 MUL .. 7 REMU), rs1, rs2
//   rsp_valid_o/rsp_ready_i      response handshake
//   rsp_data_o                   result
//   eng_en_po                    one-cycle engine start pulse
//   eng_operator_o               0 multiply, 1 divide
//   eng_tc_mode_o                bit0: a signed, bit1: b signed
//   eng_a_o, eng_b_o             engine operands
//   eng_c_vld_i, eng_c_i         engine result pulse, product or {rem, quo}

module mdu_issue #(
   parameter int DW = 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [2:0]      req_op_i,
   input  logic [DW-1:0]   req_a_i,
   input  logic [DW-1:0]   req_b_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [DW-1:0]   rsp_data_o,
   output logic            eng_en_po,
   output logic            eng_operator_o,
   output logic [1:0]      eng_tc_mode_o,
   output logic [DW-1:0]   eng_a_o,
   output logic [DW-1:0]   eng_b_o,
   input  logic            eng_c_vld_i,
   input  logic [2*DW-1:0] eng_c_i
);

   localparam int C_DW = DW * 2;

   localparam logic [DW-1:0] MIN_NEG  = {1'b1, {(DW-1){1'b0}}};
   localparam logic [DW-1:0] ALL_ONES = {DW{1'b1}};

   typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

   state_t        state_q, state_d;
   logic [2:0]    op_q;
   logic [1:0]    tc_q;
   logic [DW-1:0] a_q, b_q, rsp_data_q;

   logic          accept, load_sc, load_eng;
   logic          is_div, is_rem, is_sgn, div_zero, div_ovf;
   logic [1:0]    tc_dec;
   logic [DW-1:0] sc_data, eng_sel;

   // Request-side decode; shortcuts are judged on the operands being latched.
   always_comb begin
      is_div   = req_op_i[2];
      is_rem   = req_op_i[1];
      is_sgn   = ~req_op_i[0];
      div_zero = is_div && (req_b_i == '0);
      div_ovf  = is_div && is_sgn && (req_a_i == MIN_NEG) && (req_b_i == ALL_ONES);
      sc_data  = '0;
      if (div_zero)
         sc_data = is_rem ? req_a_i : ALL_ONES;
      else if (div_ovf)
         sc_data = is_rem ? '0 : MIN_NEG;
      // Divides share signedness on both operands; MULHSU is the odd one out.
      if (is_div)
         tc_dec = {is_sgn, is_sgn};
      else
         tc_dec = {~req_op_i[1], ~(req_op_i[1] & req_op_i[0])};
   end

   // MUL, DIV and DIVU take the low half; the rest take the high half.
   always_comb begin
      if (op_q == 3'd0 || op_q == 3'd4 || op_q == 3'd5)
         eng_sel = eng_c_i[DW-1:0];
      else
         eng_sel = eng_c_i[C_DW-1:DW];
   end

   always_comb begin
      state_d     = state_q;
      req_ready_o = 1'b0;
      accept      = 1'b0;
      load_sc     = 1'b0;
      load_eng    = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready_o = ~rst_i;
            if (req_valid_i) begin
               accept = 1'b1;
               if (div_zero || div_ovf) begin
                  load_sc = 1'b1;
                  state_d = RESP;
               end else begin
                  state_d = START;
               end
            end
         end
         START: state_d = WAIT;
         WAIT: begin
            if (eng_c_vld_i) begin
               load_eng = 1'b1;
               state_d  = RESP;
            end
         end
         RESP: begin
            if (rsp_ready_i)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         op_q       <= '0;
         tc_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         rsp_data_q <= '0;
      end else begin
         state_q <= state_d;
         // Operands only load in IDLE, so the engine pins stay frozen until
         // the current operation has fully retired.
         if (accept) begin
            op_q <= req_op_i;
            tc_q <= tc_dec;
            a_q  <= req_a_i;
            b_q  <= req_b_i;
         end
         if (load_sc)
            rsp_data_q <= sc_data;
         else if (load_eng)
            rsp_data_q <= eng_sel;
      end
   end

   assign rsp_valid_o    = (state_q == RESP);
   assign rsp_data_o     = rsp_data_q;
   assign eng_en_po      = (state_q == START);
   assign eng_operator_o = op_q[2];
   assign eng_tc_mode_o  = tc_q;
   assign eng_a_o        = a_q;
   assign eng_b_o        = b_q;

endmodule

// File: tb/tb_mdu_issue.sv
// tb_mdu_issue: self-checking bench for mdu_issue with a behavioural engine
// that answers DW+1 cycles after the start pulse, computing from the operand
// and mode pins as they stand when it answers.

module tb_mdu_issue;

   localparam int DW   = 8;
   localparam int C_DW = 2 * DW;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic [2:0]      req_op = '0;
   logic [DW-1:0]   req_a = '0, req_b = '0;
   logic            rsp_valid;
   logic            rsp_ready = 1'b0;
   logic [DW-1:0]   rsp_data;
   logic            eng_en;
   logic            eng_operator;
   logic [1:0]      eng_tc;
   logic [DW-1:0]   eng_a, eng_b;
   logic            eng_vld_q = 1'b0;
   logic            stray_vld = 1'b0;
   logic            eng_c_vld;
   logic [C_DW-1:0] eng_c = '0;
   int              eng_cnt = 0;

   int compared   = 0;
   int mismatched = 0;
   logic [DW-1:0] exp_q[$];

   always #5 clk = ~clk;

   assign eng_c_vld = eng_vld_q | stray_vld;

   mdu_issue #(.DW(DW)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
      .eng_en_po(eng_en), .eng_operator_o(eng_operator), .eng_tc_mode_o(eng_tc),
      .eng_a_o(eng_a), .eng_b_o(eng_b),
      .eng_c_vld_i(eng_c_vld), .eng_c_i(eng_c)
   );

   function automatic logic [C_DW-1:0] eng_model(input logic oper, input logic [1:0] tc,
                                                 input logic [DW-1:0] a, input logic [DW-1:0] b);
      longint sa, sb, p, q, r;
      logic [63:0] pv, qv, rv;
      sa = tc[0] ? longint'($signed(a)) : longint'(a);
      sb = tc[1] ? longint'($signed(b)) : longint'(b);
      if (!oper) begin
         p = sa * sb;
         pv = p;
         return pv[C_DW-1:0];
      end
      if (sb == 0) return '1;
      q = sa / sb;
      r = sa % sb;
      qv = q;
      rv = r;
      return {rv[DW-1:0], qv[DW-1:0]};
   endfunction

   // Engine: start pulse seen at an edge, result pulse DW+1 cycles later.
   always @(posedge clk) begin
      eng_vld_q <= 1'b0;
      if (rst) begin
         eng_cnt <= 0;
      end else if (eng_en) begin
         eng_cnt <= DW;
      end else if (eng_cnt != 0) begin
         eng_cnt <= eng_cnt - 1;
         if (eng_cnt == 1) begin
            eng_vld_q <= 1'b1;
            eng_c     <= eng_model(eng_operator, eng_tc, eng_a, eng_b);
         end
      end
   end

   task automatic run_op(input string name, input logic [2:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [DW-1:0] expv, input bit sc,
                         input logic [1:0] exp_tc);
      int cyc, en_cnt, en_cyc, exp_lat;
      bit pins_bad;
      logic [DW-1:0] want;
      @(negedge clk);
      compared++;
      if (req_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL %s ready_before: got %b want 1", name, req_ready);
      end
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      exp_q.push_back(expv);
      @(negedge clk);
      req_valid = 1'b0;
      cyc = 1; en_cnt = 0; en_cyc = -1; pins_bad = 1'b0;
      while (rsp_valid !== 1'b1 && cyc < 200) begin
         if (eng_en === 1'b1) begin en_cnt++; en_cyc = cyc; end
         if (!sc && (eng_tc !== exp_tc || eng_operator !== op[2] || eng_a !== a || eng_b !== b))
            pins_bad = 1'b1;
         @(negedge clk);
         cyc++;
      end
      exp_lat = sc ? 1 : DW + 3;
      compared++;
      if (cyc != exp_lat) begin
         mismatched++;
         $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
      end
      compared++;
      if (en_cnt != (sc ? 0 : 1)) begin
         mismatched++;
         $display("FAIL %s en_pulses: got %0d want %0d", name, en_cnt, sc ? 0 : 1);
      end
      if (!sc) begin
         compared++;
         if (en_cyc != 1 || pins_bad) begin
            mismatched++;
            $display("FAIL %s engine_pins: en_cyc %0d want 1, pins_bad %b want 0", name, en_cyc, pins_bad);
         end
      end
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      compared++;
      if (rsp_data !== want) begin
         mismatched++;
         $display("FAIL %s data: got %h want %h", name, rsp_data, want);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      compared++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL %s retire: rsp_valid %b req_ready %b want 0 1", name, rsp_valid, req_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      compared++;
      if (req_ready !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_ready_in_reset: got %b want 0", req_ready);
      end
      rst = 1'b0;
      #1;
      compared++;
      if ({rsp_valid, rsp_data, eng_en, eng_operator, eng_tc, eng_a, eng_b} !== '0 || req_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_values: vld %b data %h en %b oper %b tc %b a %h b %h rdy %b want all 0, rdy 1",
                  rsp_valid, rsp_data, eng_en, eng_operator, eng_tc, eng_a, eng_b, req_ready);
      end
   endtask

   task automatic test_mul();
      run_op("mul",    3'd0, 8'hFD, 8'h05, 8'hF1, 1'b0, 2'b11);
      run_op("mulh",   3'd1, 8'h80, 8'h80, 8'h40, 1'b0, 2'b11);
      run_op("mulhu",  3'd3, 8'hFF, 8'hFF, 8'hFE, 1'b0, 2'b00);
      run_op("mulhsu", 3'd2, 8'hFF, 8'hFF, 8'hFF, 1'b0, 2'b01);
   endtask

   task automatic test_div();
      run_op("div",  3'd4, 8'hF9, 8'h02, 8'hFD, 1'b0, 2'b11);
      run_op("rem",  3'd6, 8'hF9, 8'h02, 8'hFF, 1'b0, 2'b11);
      run_op("divu", 3'd5, 8'hF9, 8'h02, 8'h7C, 1'b0, 2'b00);
      run_op("remu", 3'd7, 8'hF9, 8'h02, 8'h01, 1'b0, 2'b00);
   endtask

   task automatic test_shortcuts();
      run_op("divu_by0", 3'd5, 8'h35, 8'h00, 8'hFF, 1'b1, 2'b00);
      run_op("rem_by0",  3'd6, 8'h35, 8'h00, 8'h35, 1'b1, 2'b00);
      run_op("div_ovf",  3'd4, 8'h80, 8'hFF, 8'h80, 1'b1, 2'b00);
      run_op("rem_ovf",  3'd6, 8'h80, 8'hFF, 8'h00, 1'b1, 2'b00);
      run_op("div_by0",  3'd4, 8'h80, 8'h00, 8'hFF, 1'b1, 2'b00);
   endtask

   task automatic test_stray_vld();
      @(negedge clk);
      stray_vld = 1'b1;
      @(negedge clk);
      stray_vld = 1'b0;
      compared++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL stray_vld: rsp_valid %b req_ready %b want 0 1", rsp_valid, req_ready);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      bit bad;
      logic [DW-1:0] want;
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'd0; req_a = 8'h07; req_b = 8'h06;
      exp_q.push_back(8'h2A);
      @(negedge clk);
      cyc = 1; bad = 1'b0;
      while (rsp_valid !== 1'b1 && cyc < 200) begin
         if (eng_a !== 8'h07 || eng_b !== 8'h06 || req_ready !== 1'b0) bad = 1'b1;
         req_a = 8'($urandom);
         req_b = 8'($urandom);
         @(negedge clk);
         cyc++;
      end
      compared++;
      if (bad || cyc != DW + 3) begin
         mismatched++;
         $display("FAIL bp_busy: pins_bad %b latency %0d want 0 %0d", bad, cyc, DW + 3);
      end
      req_a = 8'h02; req_b = 8'h09;
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (rsp_valid !== 1'b1 || rsp_data !== want || req_ready !== 1'b0 || eng_en !== 1'b0) bad = 1'b1;
         @(negedge clk);
      end
      compared++;
      if (bad || rsp_data !== want) begin
         mismatched++;
         $display("FAIL bp_hold: data %h want %h, unstable %b", rsp_data, want, bad);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      compared++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || eng_en !== 1'b0) begin
         mismatched++;
         $display("FAIL bp_idle: rsp_valid %b req_ready %b eng_en %b want 0 1 0", rsp_valid, req_ready, eng_en);
      end
      exp_q.push_back(8'h12);
      @(negedge clk);
      req_valid = 1'b0;
      compared++;
      if (eng_en !== 1'b1 || eng_a !== 8'h02 || eng_b !== 8'h09) begin
         mismatched++;
         $display("FAIL bp_second_start: en %b a %h b %h want 1 02 09", eng_en, eng_a, eng_b);
      end
      cyc = 1;
      while (rsp_valid !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      compared++;
      if (cyc != DW + 3 || rsp_data !== want) begin
         mismatched++;
         $display("FAIL bp_second: latency %0d data %h want %0d %h", cyc, rsp_data, DW + 3, want);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit seen;
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'd4; req_a = 8'h64; req_b = 8'h07;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      compared++;
      if (req_ready !== 1'b0) begin
         mismatched++;
         $display("FAIL rst_mid_ready: got %b want 0", req_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      compared++;
      if ({rsp_valid, rsp_data, eng_en, eng_operator, eng_tc, eng_a, eng_b} !== '0 || req_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL rst_mid_values: vld %b data %h en %b oper %b tc %b a %h b %h rdy %b want all 0, rdy 1",
                  rsp_valid, rsp_data, eng_en, eng_operator, eng_tc, eng_a, eng_b, req_ready);
      end
      seen = 1'b0;
      rsp_ready = 1'b1;
      repeat (2 * DW + 4) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || eng_en !== 1'b0) seen = 1'b1;
      end
      rsp_ready = 1'b0;
      compared++;
      if (seen) begin
         mismatched++;
         $display("FAIL rst_mid_no_rsp: activity seen %b want 0", seen);
      end
      run_op("mul_after_rst", 3'd0, 8'h03, 8'h04, 8'h0C, 1'b0, 2'b11);
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_shortcuts();
      test_stray_vld();
      test_back_to_back();
      test_reset_mid();
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
